// File: rtl/deemph_mc_if.sv
// Frame handshake bundle for deemph_mc: input frame with valid/ready, mode and clear
// controls, and the filtered output frame with its one-cycle strobe.
interface deemph_mc_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                mode;
    logic                      clear;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      out_valid;

    modport master (
        output in_data, in_valid, mode, clear,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, clear,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/deemph_mc.sv
// Multichannel FM de-emphasis (one-pole IIR, 50/75 us or bypass) on one shared multiplier.
// Latency CHANNELS+2 cycles per frame; in_ready low while busy; output has no backpressure.
module deemph_mc #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int COEF_W   = 18,
    parameter int B50      = 60914,
    parameter int B75      = 44664
) (
    input  logic       clk,
    input  logic       reset,
    deemph_mc_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = WIDTH + COEF_W + 2;
    localparam logic [CW-1:0]        LAST = CW'(CHANNELS - 1);
    localparam logic signed [PW-1:0] RND  = PW'(1) << (COEF_W - 2);
    localparam logic signed [PW-1:0] MAXV = (PW'(1) << (WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [1:0]                mode_q;
    logic signed [WIDTH-1:0]   x_q [CHANNELS];
    logic signed [WIDTH-1:0]   y_q [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] out_q;
    logic                      out_valid_q;

    logic signed [WIDTH-1:0]   x_cur;
    logic signed [WIDTH-1:0]   y_cur;
    logic signed [WIDTH-1:0]   y_new;
    logic [COEF_W-1:0]         b_sel;
    logic signed [WIDTH:0]     d;
    logic signed [PW-1:0]      prod;
    logic signed [PW-1:0]      p;
    logic signed [PW-1:0]      sum;

    // Shared datapath: operates on the channel selected by cnt.
    always_comb begin
        x_cur = x_q[cnt];
        y_cur = y_q[cnt];
        b_sel = (mode_q == 2'd1) ? COEF_W'(B75) : COEF_W'(B50);
        d     = $signed({x_cur[WIDTH-1], x_cur}) - $signed({y_cur[WIDTH-1], y_cur});
        prod  = PW'(d) * $signed(PW'({1'b0, b_sel}));
        p     = (prod + RND) >>> (COEF_W - 1);
        sum   = PW'(y_cur) + p;
        if (mode_q[1]) begin
            y_new = x_cur;
        end else if (sum > MAXV) begin
            y_new = MAXV[WIDTH-1:0];
        end else if (sum < MINV) begin
            y_new = MINV[WIDTH-1:0];
        end else begin
            y_new = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            mode_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // clear has priority over a coincident frame
                    if (bus.clear) begin
                        out_q <= '0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            y_q[i] <= '0;
                        end
                    end else if (bus.in_valid) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            x_q[i] <= bus.in_data[i*WIDTH +: WIDTH];
                        end
                        mode_q <= bus.mode;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    y_q[cnt] <= y_new;
                    if (cnt == LAST) begin
                        state <= OUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OUT: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        out_q[i*WIDTH +: WIDTH] <= y_q[i];
                    end
                    out_valid_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !bus.clear && !reset;
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_deemph_mc.sv
// Self-checking bench for deemph_mc: vector table through a scoreboard plus latency, reset,
// clear and long-run settling sequences.
module tb_deemph_mc;
    localparam int W  = 16;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    deemph_mc_if #(.WIDTH(W), .CHANNELS(CH)) bus();

    deemph_mc #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit              chk;
        logic [2*W-1:0]  exp;
    } sb_t;

    typedef struct {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic [1:0]          m;
        bit                  clr;
        logic signed [W-1:0] ea;
        logic signed [W-1:0] eb;
    } vec_t;

    sb_t            sb[$];
    vec_t           tbl[7];
    int             checks = 0;
    int             errors = 0;
    int             out_count = 0;
    logic [2*W-1:0] last_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            sb_t e;
            out_count++;
            last_out = bus.out_data;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got strobe with data %0h expected no strobe", bus.out_data);
            end else begin
                e = sb.pop_front();
                if (e.chk) check("out_data", bus.out_data, e.exp);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready === 1'b1) break;
            @(negedge clk);
        end
        check("in_ready_wait", bus.in_ready, 1);
    endtask

    task automatic wait_out(input int c0);
        for (int i = 0; i < 20 && out_count == c0; i++) begin
            @(negedge clk);
            #1;
        end
        check("out_strobe_seen", (out_count != c0), 1);
    endtask

    task automatic send(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        input logic [1:0] m, input bit chk,
                        input logic signed [W-1:0] ea, input logic signed [W-1:0] eb,
                        input bit clr_mid);
        int c0;
        wait_ready();
        c0 = out_count;
        bus.in_data  = {b, a};
        bus.mode     = m;
        bus.in_valid = 1'b1;
        sb.push_back('{chk, {eb, ea}});
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after acceptance; the frame in flight must not see them.
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.mode     = 2'($urandom_range(0, 3));
        if (clr_mid) bus.clear = 1'b1;
        wait_out(c0);
        bus.clear = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clear_zeroes_out", bus.out_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] lat_exp[5];
        int c0;
        int cur;
        int prev;

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.mode     = 2'd0;
        bus.clear    = 1'b0;

        tbl[0] = '{16'sd16384,  16'sd0,     2'd0, 1'b0, 16'sd7614,   16'sd0};
        tbl[1] = '{16'sd16384,  16'sd0,     2'd0, 1'b1, 16'sd11690,  16'sd0};
        tbl[2] = '{-16'sd32768, 16'sd32767, 2'd2, 1'b0, -16'sd32768, 16'sd32767};
        tbl[3] = '{-16'sd32768, 16'sd32767, 2'd1, 1'b0, -16'sd32768, 16'sd32767};
        tbl[4] = '{16'sd1000,   -16'sd1000, 2'd3, 1'b0, 16'sd1000,   -16'sd1000};
        tbl[5] = '{16'sd0,      16'sd0,     2'd1, 1'b0, 16'sd659,    -16'sd659};
        tbl[6] = '{16'sd32767,  -16'sd32768,2'd0, 1'b0, 16'sd15581,  -16'sd15581};

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].m, 1'b1, tbl[i].ea, tbl[i].eb, tbl[i].clr);
            @(negedge clk);
            @(negedge clk);
            check("out_hold", bus.out_data, {tbl[i].eb, tbl[i].ea});
        end

        // Back-to-back frames with in_valid held high; {in_ready, out_valid} per cycle.
        lat_exp = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
        wait_ready();
        bus.in_data  = {-16'sd222, 16'sd111};
        bus.mode     = 2'd2;
        bus.in_valid = 1'b1;
        sb.push_back('{1'b1, {-16'sd222, 16'sd111}});
        sb.push_back('{1'b1, {-16'sd222, 16'sd111}});
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("lat_cycle%0d", k + 1), {bus.in_ready, bus.out_valid}, lat_exp[k]);
        end
        bus.in_valid = 1'b0;
        wait_out(out_count);

        // Reset in the middle of CALC aborts the frame.
        wait_ready();
        bus.in_data  = {16'sd0, 16'sd16384};
        bus.mode     = 2'd0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        c0 = out_count;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", bus.in_ready, 1);
        repeat (6) @(negedge clk);
        #1;
        check("midrst_no_strobe", out_count, c0);
        send(16'sd16384, 16'sd0, 2'd0, 1'b1, 16'sd7614, 16'sd0, 1'b0);

        // clear coinciding with in_valid wins.
        wait_ready();
        bus.in_data  = {16'sd0, 16'sd16384};
        bus.mode     = 2'd0;
        bus.in_valid = 1'b1;
        bus.clear    = 1'b1;
        #1;
        check("clear_blocks_ready", bus.in_ready, 0);
        c0 = out_count;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        check("clear_out_data", bus.out_data, 0);
        repeat (4) @(negedge clk);
        #1;
        check("clear_no_strobe", out_count, c0);
        send(16'sd16384, 16'sd0, 2'd0, 1'b1, 16'sd7614, 16'sd0, 1'b0);

        // Step response, 50 us: monotonic rise to within 1 LSB of the input.
        do_clear();
        prev = 0;
        for (int n = 0; n < 25; n++) begin
            send(16'sd16384, 16'sd0, 2'd0, 1'b0, 16'sd0, 16'sd0, 1'b0);
            cur = $signed(last_out[W-1:0]);
            check("rise_monotonic", (cur >= prev), 1);
            prev = cur;
        end
        check("rise_settle", (prev >= 16383 && prev <= 16385), 1);
        check("rise_ch1_zero", last_out[2*W-1:W], 0);

        // Negative full-scale step, 75 us: never wraps, settles at the rail.
        do_clear();
        prev = 0;
        for (int n = 0; n < 40; n++) begin
            send(-16'sd32768, 16'sd0, 2'd1, 1'b0, 16'sd0, 16'sd0, 1'b0);
            cur = $signed(last_out[W-1:0]);
            check("fall_monotonic_nowrap", (cur <= prev && cur <= 0), 1);
            prev = cur;
        end
        check("fall_settle", (prev == -32768 || prev == -32767), 1);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
